// File: rtl/axi_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : axi_mem_arbiter
//  Description : Shares one AXI memory slave between the instruction-fetch
//                unit (read only) and the load/store unit (read or write).
//                Exactly one transaction is in flight at a time, so a read
//                can never overtake an earlier write.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_mem_arbiter #(
    parameter bit PRIO_LSU = 1'b1
) (
    input  logic         clock,
    input  logic         reset,
    // instruction-fetch unit
    input  logic         ifu_req,
    input  logic [63:0]  ifu_addr,
    output logic         ifu_rvalid,
    output logic [127:0] ifu_rdata,
    // load/store unit
    input  logic         lsu_req,
    input  logic         lsu_we,
    input  logic [63:0]  lsu_addr,
    input  logic [63:0]  lsu_wdata,
    input  logic [7:0]   lsu_wstrb,
    output logic         lsu_resp,
    output logic [63:0]  lsu_rdata,
    // AXI slave: read channels
    output logic [63:0]  s_araddr,
    output logic         s_arvalid,
    input  logic         s_arready,
    input  logic [63:0]  s_rdata,
    input  logic [127:0] s_icache_rdata,
    input  logic         s_rvalid,
    output logic         s_rready,
    // AXI slave: write channels
    output logic [63:0]  s_awaddr,
    output logic         s_awvalid,
    input  logic         s_awready,
    output logic [63:0]  s_wdata,
    output logic [7:0]   s_wstrb,
    output logic         s_wvalid,
    input  logic         s_wready,
    input  logic         s_bvalid,
    output logic         s_bready
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD_A = 3'd1,
        S_RD_D = 3'd2,
        S_WR_A = 3'd3,
        S_WR_B = 3'd4,
        S_RESP = 3'd5
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic           r_gnt_lsu;     // 1: current transaction belongs to LSU
    logic           r_rr_lsu;      // 1: LSU was the last master served
    logic [63:0]    r_addr;
    logic [63:0]    r_wdata;
    logic [7:0]     r_wstrb;
    logic [127:0]   r_ifu_rdata;
    logic [63:0]    r_lsu_rdata;
    logic           w_pick_lsu;

    // W-ready always arrives together with B-valid, so B alone closes a write.
    logic           w_unused_wready;
    assign w_unused_wready = s_wready;

    // Arbitration: fixed LSU priority, or round-robin favouring the master not served last.
    always_comb begin
        w_pick_lsu = 1'b0;
        if (PRIO_LSU)
            w_pick_lsu = lsu_req;
        else
            w_pick_lsu = lsu_req && (!ifu_req || !r_rr_lsu);
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // Next-state logic: one AR/R or AW/W/B sequence per grant, then a response cycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_pick_lsu)
                    w_next = lsu_we ? S_WR_A : S_RD_A;
                else if (ifu_req)
                    w_next = S_RD_A;
            end
            S_RD_A:  if (s_arready) w_next = S_RD_D;
            S_RD_D:  if (s_rvalid)  w_next = S_RESP;
            S_WR_A:  if (s_awready) w_next = S_WR_B;
            S_WR_B:  if (s_bvalid)  w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: latch the granted request, capture read data, advance the rr pointer.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_gnt_lsu   <= 1'b0;
            r_rr_lsu    <= 1'b1;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_ifu_rdata <= '0;
            r_lsu_rdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pick_lsu) begin
                        r_gnt_lsu <= 1'b1;
                        r_addr    <= lsu_addr;
                        r_wdata   <= lsu_wdata;
                        r_wstrb   <= lsu_wstrb;
                    end else if (ifu_req) begin
                        r_gnt_lsu <= 1'b0;
                        r_addr    <= ifu_addr;
                    end
                end
                S_RD_D: begin
                    if (s_rvalid) begin
                        if (r_gnt_lsu)
                            r_lsu_rdata <= s_rdata;
                        else
                            r_ifu_rdata <= s_icache_rdata;
                    end
                end
                S_RESP:  r_rr_lsu <= r_gnt_lsu;
                default: ;
            endcase
        end
    end

    // Handshake outputs decode the registered state only, never the slave inputs.
    assign s_arvalid  = (r_state == S_RD_A);
    assign s_rready   = (r_state == S_RD_D);
    assign s_awvalid  = (r_state == S_WR_A);
    assign s_wvalid   = (r_state == S_WR_A) || (r_state == S_WR_B);
    assign s_bready   = (r_state == S_WR_B);
    assign s_araddr   = r_addr;
    assign s_awaddr   = r_addr;
    assign s_wdata    = r_wdata;
    assign s_wstrb    = r_wstrb;

    assign ifu_rvalid = (r_state == S_RESP) && !r_gnt_lsu;
    assign lsu_resp   = (r_state == S_RESP) &&  r_gnt_lsu;
    assign ifu_rdata  = r_ifu_rdata;
    assign lsu_rdata  = r_lsu_rdata;

endmodule
`default_nettype wire
